// File: rtl/matrix_loader_if.sv
// Beat stream in, assembled matrices and systolic-array handshake out.
// The loader sits on the slave side; whatever feeds it uses master.
interface matrix_loader_if;
    logic [7:0]            i_data;
    logic                  i_dataValid;
    logic                  o_dataReady;
    logic                  i_dataLast;
    logic [3:0][3:0][7:0]  o_a;
    logic [3:0][3:0][7:0]  o_b;
    logic                  o_validInput;
    logic                  i_validResult;
    logic                  o_busy;
    logic                  o_error;
    logic                  i_clearError;

    modport slave (
        input  i_data, i_dataValid, i_dataLast, i_validResult, i_clearError,
        output o_dataReady, o_a, o_b, o_validInput, o_busy, o_error
    );

    modport master (
        output i_data, i_dataValid, i_dataLast, i_validResult, i_clearError,
        input  o_dataReady, o_a, o_b, o_validInput, o_busy, o_error
    );
endinterface

// File: rtl/matrix_loader.sv
// Collects 32 byte beats into two 4x4 matrices (A then B, row-major), launches
// the systolic array with a one-cycle pulse and waits, bounded, for its result.
module matrix_loader #(
    parameter int RESULT_TIMEOUT = 32
) (
    input  logic            i_clk,
    input  logic            i_arst_n,
    matrix_loader_if.slave  bus
);

    typedef enum logic [1:0] {LOAD, FIRE, WAIT} state_t;

    state_t               state;
    logic [4:0]           beat_k;
    logic [7:0]           wait_cnt;
    logic                 ready_q;
    logic                 fire_q;
    logic                 error_q;
    logic [3:0][3:0][7:0] mat_a;
    logic [3:0][3:0][7:0] mat_b;

    logic xfer;
    logic last_early;
    logic last_missing;
    logic timeout_hit;

    always_comb begin
        xfer         = bus.i_dataValid && ready_q;
        last_early   = xfer && bus.i_dataLast && (beat_k != 5'd31);
        last_missing = xfer && !bus.i_dataLast && (beat_k == 5'd31);
        // A result in the timeout cycle takes priority over the timeout.
        timeout_hit  = (state == WAIT) && !bus.i_validResult
                       && (wait_cnt == 8'(RESULT_TIMEOUT - 1));
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state    <= LOAD;
            beat_k   <= 5'd0;
            wait_cnt <= 8'd0;
            ready_q  <= 1'b0;
            fire_q   <= 1'b0;
            error_q  <= 1'b0;
            mat_a    <= '0;
            mat_b    <= '0;
        end else begin
            fire_q <= 1'b0;
            case (state)
                LOAD: begin
                    ready_q <= 1'b1;
                    if (xfer) begin
                        if (last_early || last_missing) begin
                            beat_k <= 5'd0;
                        end else begin
                            if (beat_k[4])
                                mat_b[beat_k[3:2]][beat_k[1:0]] <= bus.i_data;
                            else
                                mat_a[beat_k[3:2]][beat_k[1:0]] <= bus.i_data;
                            if (beat_k == 5'd31) begin
                                state   <= FIRE;
                                ready_q <= 1'b0;
                                fire_q  <= 1'b1;
                                beat_k  <= 5'd0;
                            end else begin
                                beat_k <= beat_k + 5'd1;
                            end
                        end
                    end
                end
                FIRE: begin
                    state    <= WAIT;
                    wait_cnt <= 8'd0;
                end
                WAIT: begin
                    if (bus.i_validResult || timeout_hit) begin
                        state    <= LOAD;
                        ready_q  <= 1'b1;
                        wait_cnt <= 8'd0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                default: begin
                    state   <= LOAD;
                    ready_q <= 1'b1;
                end
            endcase
            // Set beats clear when both happen on the same edge.
            if (last_early || last_missing || timeout_hit)
                error_q <= 1'b1;
            else if (bus.i_clearError)
                error_q <= 1'b0;
        end
    end

    assign bus.o_dataReady  = ready_q;
    assign bus.o_validInput = fire_q;
    assign bus.o_error      = error_q;
    assign bus.o_busy       = (state == FIRE) || (state == WAIT);
    assign bus.o_a          = mat_a;
    assign bus.o_b          = mat_b;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed bench for matrix_loader; a queue-backed monitor checks every launch.
module tb_matrix_loader;

    logic clk = 1'b0;
    logic arst_n;
    always #5 clk = ~clk;

    matrix_loader_if ifa ();
    matrix_loader_if ift ();

    assign ift.i_data        = ifa.i_data;
    assign ift.i_dataValid   = ifa.i_dataValid;
    assign ift.i_dataLast    = ifa.i_dataLast;
    assign ift.i_validResult = ifa.i_validResult;
    assign ift.i_clearError  = ifa.i_clearError;

    matrix_loader dut (.i_clk(clk), .i_arst_n(arst_n), .bus(ifa));
    matrix_loader #(.RESULT_TIMEOUT(4)) dut_t (.i_clk(clk), .i_arst_n(arst_n), .bus(ift));

    typedef logic [3:0][3:0][7:0] mat_t;
    typedef struct packed { mat_t a; mat_t b; } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    mat_t snap_a = '0;
    mat_t snap_b = '0;
    logic prev_vi = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Scoreboard monitor: every launch pulse must match the oldest queued pair.
    always @(negedge clk) begin
        exp_t e;
        if (ifa.o_validInput === 1'b1) begin
            chk("pulse_width", 128'(prev_vi), 128'(0));
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse: got launch pulse, required none");
            end else begin
                e = exp_q.pop_front();
                chk("mat_a", ifa.o_a, e.a);
                chk("mat_b", ifa.o_b, e.b);
            end
            snap_a = ifa.o_a;
            snap_b = ifa.o_b;
        end else if (ifa.o_busy === 1'b1) begin
            chk("hold_a", ifa.o_a, snap_a);
            chk("hold_b", ifa.o_b, snap_b);
        end
        prev_vi = ifa.o_validInput;
    end

    function automatic logic [7:0] val(input int pat, input int i);
        case (pat)
            0:       return 8'(i + 1);
            1:       return 8'(i * 7 + 3);
            default: return 8'(255 - i);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        logic acc;
        acc = 1'b0;
        ifa.i_data      = d;
        ifa.i_dataLast  = l;
        ifa.i_dataValid = 1'b1;
        for (int t = 0; t < 64 && !acc; t++) begin
            @(negedge clk);
            acc = ifa.o_dataReady;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ready stayed 0, required 1");
        end
        ifa.i_dataValid = 1'b0;
        ifa.i_dataLast  = 1'b0;
        ifa.i_data      = 8'hEE;
    endtask

    task automatic load(input int pat, input bit gap, input bit expect_fire);
        mat_t ea, eb;
        ea = '0;
        eb = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < 16) ea[2'(i / 4)][2'(i % 4)] = val(pat, i);
            else        eb[2'((i - 16) / 4)][2'((i - 16) % 4)] = val(pat, i);
        end
        if (expect_fire) exp_q.push_back({ea, eb});
        for (int i = 0; i < 32; i++) begin
            send(val(pat, i), i == 31);
            if (gap && i != 31) tick();
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ready"}, 128'(ifa.o_dataReady), 128'(0));
        chk({tag, "_vi"},    128'(ifa.o_validInput), 128'(0));
        chk({tag, "_busy"},  128'(ifa.o_busy), 128'(0));
        chk({tag, "_error"}, 128'(ifa.o_error), 128'(0));
        chk({tag, "_a"},     ifa.o_a, 128'(0));
        chk({tag, "_b"},     ifa.o_b, 128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int nrdy;
        arst_n            = 1'b0;
        ifa.i_data        = 8'h00;
        ifa.i_dataValid   = 1'b0;
        ifa.i_dataLast    = 1'b0;
        ifa.i_validResult = 1'b0;
        ifa.i_clearError  = 1'b0;

        repeat (2) @(negedge clk);
        check_reset("rst");
        arst_n = 1'b1;
        #1;
        chk("ready_pre_edge", 128'(ifa.o_dataReady), 128'(0));
        tick();
        chk("ready_first_edge", 128'(ifa.o_dataReady), 128'(1));

        // Basic 1..32 load, launch and result.
        load(0, 1'b0, 1'b1);
        chk("t1_vi", 128'(ifa.o_validInput), 128'(1));
        chk("t1_ready", 128'(ifa.o_dataReady), 128'(0));
        chk("t1_busy", 128'(ifa.o_busy), 128'(1));
        chk("t1_a00", 128'(ifa.o_a[0][0]), 128'(1));
        chk("t1_a33", 128'(ifa.o_a[3][3]), 128'(16));
        chk("t1_b00", 128'(ifa.o_b[0][0]), 128'(17));
        chk("t1_b33", 128'(ifa.o_b[3][3]), 128'(32));
        tick();
        chk("t1_vi_off", 128'(ifa.o_validInput), 128'(0));
        chk("t1_wait_busy", 128'(ifa.o_busy), 128'(1));
        ifa.i_validResult = 1'b1;
        tick();
        ifa.i_validResult = 1'b0;
        chk("t1_back_ready", 128'(ifa.o_dataReady), 128'(1));
        chk("t1_back_busy", 128'(ifa.o_busy), 128'(0));

        // Result strobe while loading is ignored.
        ifa.i_validResult = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("load_ign_ready", 128'(ifa.o_dataReady), 128'(1));
            chk("load_ign_busy", 128'(ifa.o_busy), 128'(0));
        end
        ifa.i_validResult = 1'b0;

        // 50% valid duty, result five cycles after the launch.
        load(0, 1'b1, 1'b1);
        nrdy = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (!ifa.o_dataReady) nrdy++;
            if (c == 5) ifa.i_validResult = 1'b1;
            @(posedge clk);
            #1;
        end
        ifa.i_validResult = 1'b0;
        @(negedge clk);
        chk("t2_ready_back", 128'(ifa.o_dataReady), 128'(1));
        chk("t2_ready_low_cycles", 128'(nrdy), 128'(6));

        // Early last on beat 10, then a clean load.
        for (int i = 0; i < 9; i++) send(val(0, i), 1'b0);
        send(8'd10, 1'b1);
        chk("t3_error", 128'(ifa.o_error), 128'(1));
        chk("t3_ready", 128'(ifa.o_dataReady), 128'(1));
        chk("t3_busy", 128'(ifa.o_busy), 128'(0));
        ifa.i_clearError = 1'b1;
        tick();
        ifa.i_clearError = 1'b0;
        chk("t3_cleared", 128'(ifa.o_error), 128'(0));
        load(1, 1'b0, 1'b1);
        chk("t3_reload_error", 128'(ifa.o_error), 128'(0));
        ifa.i_validResult = 1'b1;
        tick();
        chk("fire_ignores_result", 128'(ifa.o_busy), 128'(1));
        tick();
        ifa.i_validResult = 1'b0;
        chk("t3_done_busy", 128'(ifa.o_busy), 128'(0));
        chk("t3_done_ready", 128'(ifa.o_dataReady), 128'(1));

        // Missing last on beat 32: error and no launch.
        for (int i = 0; i < 32; i++) send(val(1, i), 1'b0);
        chk("nolast_error", 128'(ifa.o_error), 128'(1));
        chk("nolast_busy", 128'(ifa.o_busy), 128'(0));
        ifa.i_clearError = 1'b1;
        tick();
        ifa.i_clearError = 1'b0;

        // Timeout on the RESULT_TIMEOUT=4 instance, with a colliding clear.
        @(negedge clk);
        arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        tick();
        load(2, 1'b0, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("to_wait_busy", 128'(ift.o_busy), 128'(1));
            chk("to_wait_error", 128'(ift.o_error), 128'(0));
            if (c == 4) ifa.i_clearError = 1'b1;
        end
        tick();
        ifa.i_clearError = 1'b0;
        chk("to_error", 128'(ift.o_error), 128'(1));
        chk("to_ready", 128'(ift.o_dataReady), 128'(1));
        chk("to_busy", 128'(ift.o_busy), 128'(0));
        ifa.i_clearError = 1'b1;
        tick();
        ifa.i_clearError = 1'b0;
        chk("to_cleared", 128'(ift.o_error), 128'(0));
        chk("long_to_no_error", 128'(ifa.o_error), 128'(0));
        ifa.i_validResult = 1'b1;
        tick();
        ifa.i_validResult = 1'b0;
        chk("long_to_ready", 128'(ifa.o_dataReady), 128'(1));

        // Reset after beat 20, then a full reload.
        for (int i = 0; i < 20; i++) send(val(0, i), 1'b0);
        @(negedge clk);
        arst_n = 1'b0;
        #1;
        check_reset("midrst");
        @(negedge clk);
        arst_n = 1'b1;
        tick();
        load(2, 1'b0, 1'b1);
        chk("reload_b33", 128'(ifa.o_b[3][3]), 128'(8'd224));
        ifa.i_validResult = 1'b1;
        tick();
        tick();
        ifa.i_validResult = 1'b0;
        chk("reload_ready", 128'(ifa.o_dataReady), 128'(1));

        repeat (2) tick();
        chk("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 SHALL have parameter RESULT_TIMEOUT, default 32, the maximum number of cycles spent in WAIT before an error is flagged (legal range 2..255).
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port i_arst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port i_data, input, 8 bits: one matrix element per beat, unsigned.
REQ-005 SHALL have port i_dataValid, input, 1 bit: the upstream beat is valid.
REQ-006 SHALL have port o_dataReady, output, 1 bit, registered: the block accepts a beat.
REQ-007 SHALL have port i_dataLast, input, 1 bit: marks the final (32nd) beat of a matrix pair.
REQ-008 SHALL have port o_a, output, [3:0][3:0][7:0]: assembled matrix A, indexed [row][col].
REQ-009 SHALL have port o_b, output, [3:0][3:0][7:0]: assembled matrix B, indexed [row][col].
REQ-010 SHALL have port o_validInput, output, 1 bit: one-cycle launch pulse to the systolic array.
REQ-011 SHALL have port i_validResult, input, 1 bit: the systolic array has produced its result.
REQ-012 SHALL have port o_busy, output, 1 bit: high while in FIRE or WAIT.
REQ-013 SHALL have port o_error, output, 1 bit: sticky protocol or timeout error.
REQ-014 SHALL have port i_clearError, input, 1 bit: clears o_error.

Function
REQ-015 SHALL implement FSM states LOAD, FIRE and WAIT.
REQ-016 Transfer SHALL occur only on a clock edge where i_dataValid=1 and o_dataReady=1; no other edge alters o_a, o_b or the beat counter.
REQ-017 o_dataReady SHALL be 1 only in LOAD, and SHALL be 0 in FIRE and WAIT.
REQ-018 A 5-bit beat counter k SHALL map beats as follows: k=0..15 write o_a[k/4][k%4]; k=16..31 write o_b[(k-16)/4][(k-16)%4].
REQ-019 k SHALL increment by 1 per transfer and return to 0 after beat 31 or after any error.
REQ-020 A transfer at k=31 with i_dataLast=1 SHALL write the element, move the FSM to FIRE, and deassert o_dataReady on the same edge.
REQ-021 In FIRE, o_validInput SHALL be 1 for exactly one cycle (cycle N+1 after acceptance edge N), and the FSM SHALL move to WAIT on the next edge.
REQ-022 o_a and o_b SHALL remain stable from entry into FIRE until the FSM returns to LOAD.
REQ-023 In WAIT, i_validResult=1 SHALL return the FSM to LOAD; o_dataReady SHALL be 1 in the following cycle.
REQ-024 i_validResult SHALL be ignored in LOAD and FIRE.
REQ-025 A WAIT cycle counter SHALL count from 0; on reaching RESULT_TIMEOUT with no i_validResult, the block SHALL set o_error and return to LOAD.
REQ-026 If i_validResult arrives in the same cycle the counter reaches RESULT_TIMEOUT, the result SHALL win and no error is set.
REQ-027 i_dataLast=1 on a transfer with k≠31 SHALL set o_error, leave the element unwritten, reset k to 0, and keep the FSM in LOAD.
REQ-028 A transfer at k=31 with i_dataLast=0 SHALL set o_error, reset k to 0, and produce no FIRE.
REQ-029 i_clearError=1 SHALL clear o_error on the next edge; if a new error is detected on the same edge, set SHALL win.
REQ-030 o_busy SHALL equal (state==FIRE || state==WAIT).

Reset
REQ-031 While i_arst_n=0, the block SHALL hold: state LOAD, k=0, WAIT counter 0, o_a=0, o_b=0, o_validInput=0, o_dataReady=0, o_busy=0, o_error=0.
REQ-032 o_dataReady SHALL rise on the first clock edge after i_arst_n deasserts.
REQ-033 Reset asserted mid-load or in FIRE/WAIT SHALL abort immediately with no o_validInput pulse; any partial matrix is discarded.

Verification
REQ-034 Bench SHALL stream 32 beats of values 1..32 with last on beat 32 -> o_a[0][0]=1, o_a[3][3]=16, o_b[0][0]=17, o_b[3][3]=32; o_validInput is a single pulse one cycle after the last edge.
REQ-035 Bench SHALL apply i_dataValid toggling 50% and i_validResult 5 cycles after the pulse -> the same matrices result, o_dataReady=0 for exactly 6 cycles, and no beat is lost.
REQ-036 Bench SHALL assert last on beat 10 -> o_error=1, k=0, no pulse; a subsequent clean 32-beat load fires normally.
REQ-037 Bench SHALL leave i_validResult low with RESULT_TIMEOUT=4 -> o_error=1 after 4 WAIT cycles and o_dataReady=1 on the next cycle; a simultaneous i_clearError leaves o_error=1.
REQ-038 Bench SHALL assert reset after beat 20 -> all outputs are zero; reload from beat 0 succeeds.
REQ-039 Bench SHALL drive i_validResult in LOAD -> no state change.
